// File: rtl/sensor_poll_ctrl.sv
// sensor_poll_ctrl
// Periodically triggers a DHT-style sensor driver and waits for its result. It keeps the last
// good humidity/temperature reading, raises threshold alarms with hysteresis, and flags a
// sensor fault after a run of consecutive failed reads.
//
// Ports:
//   clk, rst              system clock; asynchronous active-high reset
//   enable                level, 1 = periodic polling allowed
//   temp_th, hum_th       alarm thresholds (degC, %RH), sampled only when a read is evaluated
//   dht_start             one-cycle trigger to the sensor driver
//   dht_busy, dht_valid   driver status; dht_checksum 1 = good frame
//   dht_hum, dht_temp     driver integer results, captured on dht_valid
//   hum_out, temp_out     last good reading
//   upd                   one-cycle pulse when hum_out/temp_out update
//   temp_alarm, hum_alarm threshold alarms; alarm = temp_alarm | hum_alarm
//   sensor_fault          set after MAX_FAIL consecutive failed reads, cleared by a good read
module sensor_poll_ctrl #(
    parameter int unsigned CLK_HZ     = 40_000_000,
    parameter int unsigned POLL_MS    = 2000,
    parameter int unsigned TIMEOUT_MS = 50,
    parameter int unsigned TEMP_HYST  = 2,
    parameter int unsigned HUM_HYST   = 5,
    parameter int unsigned MAX_FAIL   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] temp_th,
    input  logic [7:0] hum_th,
    output logic       dht_start,
    input  logic       dht_busy,
    input  logic       dht_valid,
    input  logic       dht_checksum,
    input  logic [7:0] dht_hum,
    input  logic [7:0] dht_temp,
    output logic [7:0] hum_out,
    output logic [7:0] temp_out,
    output logic       upd,
    output logic       temp_alarm,
    output logic       hum_alarm,
    output logic       alarm,
    output logic       sensor_fault
);

    localparam int unsigned POLL_CYC    = CLK_HZ / 1000 * POLL_MS;
    localparam int unsigned TMO_CYC     = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam logic [31:0] POLL_LAST   = 32'(POLL_CYC - 1);
    localparam logic [31:0] TMO_LAST    = 32'(TMO_CYC - 1);
    localparam logic [31:0] BUSY_LAST   = 32'd3;
    localparam logic [7:0]  TEMP_HYST_B = 8'(TEMP_HYST);
    localparam logic [7:0]  HUM_HYST_B  = 8'(HUM_HYST);
    localparam logic [3:0]  MAX_FAIL_B  = 4'(MAX_FAIL);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_POLL   = 3'd1;
    localparam logic [2:0] S_TRIGGER     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY   = 3'd3;
    localparam logic [2:0] S_WAIT_RESULT = 3'd4;
    localparam logic [2:0] S_EVAL        = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] poll_cnt_q, poll_cnt_d;
    // Counts cycles in WAIT_BUSY (busy deadline) and in WAIT_RESULT (read timeout).
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    // Set when the driver delivered a frame; the checksum is judged in EVAL.
    logic        ok_q, ok_d;
    logic [7:0]  cap_hum_q, cap_hum_d;
    logic [7:0]  cap_temp_q, cap_temp_d;
    logic        cap_cks_q, cap_cks_d;

    logic [7:0]  hum_q, temp_q;
    logic        upd_q, temp_alarm_q, hum_alarm_q, fault_q;
    logic [3:0]  fail_cnt_q, fail_inc;

    logic        good_read, bad_read;
    logic [7:0]  temp_clr_lvl, hum_clr_lvl;
    logic        temp_alarm_nx, hum_alarm_nx;

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = '0;
        tmo_cnt_d  = '0;
        ok_d       = ok_q;
        cap_hum_d  = cap_hum_q;
        cap_temp_d = cap_temp_q;
        cap_cks_d  = cap_cks_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_POLL;
            end
            S_WAIT_POLL: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (poll_cnt_q == POLL_LAST) begin
                    state_d = S_TRIGGER;
                end else begin
                    poll_cnt_d = poll_cnt_q + 32'd1;
                end
            end
            S_TRIGGER: begin
                ok_d    = 1'b0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (dht_busy) begin
                    state_d = S_WAIT_RESULT;
                end else if (tmo_cnt_q == BUSY_LAST) begin
                    state_d = S_EVAL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_WAIT_RESULT: begin
                // valid wins over a simultaneous busy fall
                if (dht_valid) begin
                    ok_d       = 1'b1;
                    cap_hum_d  = dht_hum;
                    cap_temp_d = dht_temp;
                    cap_cks_d  = dht_checksum;
                    state_d    = S_EVAL;
                end else if (!dht_busy || tmo_cnt_q == TMO_LAST) begin
                    state_d = S_EVAL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_EVAL: begin
                state_d = enable ? S_WAIT_POLL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            poll_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            ok_q       <= 1'b0;
            cap_hum_q  <= '0;
            cap_temp_q <= '0;
            cap_cks_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ok_q       <= ok_d;
            cap_hum_q  <= cap_hum_d;
            cap_temp_q <= cap_temp_d;
            cap_cks_q  <= cap_cks_d;
        end
    end

    assign good_read = (state_q == S_EVAL) && ok_q && cap_cks_q;
    assign bad_read  = (state_q == S_EVAL) && !good_read;
    assign fail_inc  = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;

    // Clear level saturates at 0 so a small threshold can never clear via underflow.
    assign temp_clr_lvl = (temp_th > TEMP_HYST_B) ? temp_th - TEMP_HYST_B : 8'd0;
    assign hum_clr_lvl  = (hum_th > HUM_HYST_B) ? hum_th - HUM_HYST_B : 8'd0;

    always_comb begin
        temp_alarm_nx = temp_alarm_q;
        if (cap_temp_q >= temp_th) begin
            temp_alarm_nx = 1'b1;
        end else if (cap_temp_q < temp_clr_lvl) begin
            temp_alarm_nx = 1'b0;
        end
    end

    always_comb begin
        hum_alarm_nx = hum_alarm_q;
        if (cap_hum_q >= hum_th) begin
            hum_alarm_nx = 1'b1;
        end else if (cap_hum_q < hum_clr_lvl) begin
            hum_alarm_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hum_q        <= '0;
            temp_q       <= '0;
            upd_q        <= 1'b0;
            temp_alarm_q <= 1'b0;
            hum_alarm_q  <= 1'b0;
            fail_cnt_q   <= '0;
            fault_q      <= 1'b0;
        end else begin
            upd_q <= good_read;
            if (good_read) begin
                hum_q        <= cap_hum_q;
                temp_q       <= cap_temp_q;
                temp_alarm_q <= temp_alarm_nx;
                hum_alarm_q  <= hum_alarm_nx;
                fail_cnt_q   <= '0;
                fault_q      <= 1'b0;
            end else if (bad_read) begin
                fail_cnt_q <= fail_inc;
                if (fail_inc >= MAX_FAIL_B) fault_q <= 1'b1;
            end
        end
    end

    assign dht_start    = (state_q == S_TRIGGER);
    assign hum_out      = hum_q;
    assign temp_out     = temp_q;
    assign upd          = upd_q;
    assign temp_alarm   = temp_alarm_q;
    assign hum_alarm    = hum_alarm_q;
    assign alarm        = temp_alarm_q | hum_alarm_q;
    assign sensor_fault = fault_q;

endmodule
